// File: rtl/muntjac_pkg.sv
// Shared muntjac memory-interface types plus the bundled dcache request used by the harness arbiter.
package muntjac_pkg;

    typedef enum logic [2:0] {
        MEM_LOAD  = 3'd0,
        MEM_STORE = 3'd1,
        MEM_LR    = 3'd2,
        MEM_SC    = 3'd3,
        MEM_AMO   = 3'd4
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_EXT_ZERO   = 2'd0,
        SIZE_EXT_SIGNED = 2'd1,
        SIZE_EXT_ONE    = 2'd2
    } size_ext_e;

    typedef enum logic [3:0] {
        EXC_NONE           = 4'd0,
        EXC_LOAD_MISALIGN  = 4'd4,
        EXC_LOAD_ACCESS    = 4'd5,
        EXC_STORE_MISALIGN = 4'd6,
        EXC_STORE_ACCESS   = 4'd7,
        EXC_LOAD_PAGE      = 4'd13,
        EXC_STORE_PAGE     = 4'd15
    } exc_cause_e;

    typedef struct packed {
        exc_cause_e  cause;
        logic [63:0] tval;
    } exception_t;

    typedef struct packed {
        logic [63:0] address;
        logic [63:0] value;
        mem_op_e     op;
        logic [1:0]  size;
        size_ext_e   size_ext;
        logic [6:0]  amo;
        logic [63:0] atp;
        logic        prv;
        logic        sum;
        logic        mxr;
    } dcache_req_t;

endpackage

// File: rtl/dcache_harness_id_fifo.sv
// In-order FIFO holding the hart index of every outstanding memory request.
module dcache_harness_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CntW-1:0]  o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_harness_arbiter.sv
// Round-robin merge of per-hart dcache ports onto one harness memory port, with in-order
// return routing and notifications fenced behind outstanding traffic.
module dcache_harness_arbiter
    import muntjac_pkg::*;
#(
    parameter int unsigned NumHarts   = 2,
    parameter int unsigned QueueDepth = 4,
    localparam int unsigned HartW     = (NumHarts > 1) ? $clog2(NumHarts) : 1,
    localparam int unsigned CountW    = $clog2(QueueDepth + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic [NumHarts-1:0]          h_req_valid,
    output logic [NumHarts-1:0]          h_req_ready,
    input  logic [NumHarts-1:0][63:0]    h_req_address,
    input  logic [NumHarts-1:0][63:0]    h_req_value,
    input  mem_op_e [NumHarts-1:0]       h_req_op,
    input  logic [NumHarts-1:0][1:0]     h_req_size,
    input  size_ext_e [NumHarts-1:0]     h_req_size_ext,
    input  logic [NumHarts-1:0][6:0]     h_req_amo,
    input  logic [NumHarts-1:0][63:0]    h_req_atp,
    input  logic [NumHarts-1:0]          h_req_prv,
    input  logic [NumHarts-1:0]          h_req_sum,
    input  logic [NumHarts-1:0]          h_req_mxr,

    output logic [NumHarts-1:0]          h_resp_valid,
    output logic [NumHarts-1:0][63:0]    h_resp_value,
    output logic [NumHarts-1:0]          h_ex_valid,
    output exception_t [NumHarts-1:0]    h_ex_exception,

    input  logic [NumHarts-1:0]          h_notif_valid,
    input  logic [NumHarts-1:0]          h_notif_reason,
    output logic [NumHarts-1:0]          h_notif_ready,

    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [63:0]                  m_req_address,
    output logic [63:0]                  m_req_value,
    output mem_op_e                      m_req_op,
    output logic [1:0]                   m_req_size,
    output size_ext_e                    m_req_size_ext,
    output logic [6:0]                   m_req_amo,
    output logic [63:0]                  m_req_atp,
    output logic                         m_req_prv,
    output logic                         m_req_sum,
    output logic                         m_req_mxr,

    input  logic                         m_resp_valid,
    input  logic [63:0]                  m_resp_value,
    input  logic                         m_ex_valid,
    input  exception_t                   m_ex_exception,

    output logic                         m_notif_valid,
    output logic                         m_notif_reason,
    input  logic                         m_notif_ready,

    output logic [CountW-1:0]            outstanding_o,
    output logic                         err_o
);

    dcache_req_t [NumHarts-1:0] w_reqs;
    dcache_req_t                w_sel;
    logic [HartW-1:0]           r_rr;
    logic [HartW-1:0]           w_grant;
    logic [HartW-1:0]           w_rr_next;
    logic                       w_any_req;
    int unsigned                w_idx;
    logic                       w_accept;
    logic                       w_full;
    logic                       w_empty;
    logic [HartW-1:0]           w_head;
    logic [CountW-1:0]          w_count;
    logic                       w_ret_ok;
    logic                       w_ret_err;
    logic                       w_notif_block;
    logic                       w_nfound;
    logic [HartW-1:0]           w_nsel;
    logic                       r_err;

    always_comb begin
        w_reqs = '0;
        for (int unsigned h = 0; h < NumHarts; h++) begin
            w_reqs[h].address  = h_req_address[h];
            w_reqs[h].value    = h_req_value[h];
            w_reqs[h].op       = h_req_op[h];
            w_reqs[h].size     = h_req_size[h];
            w_reqs[h].size_ext = h_req_size_ext[h];
            w_reqs[h].amo      = h_req_amo[h];
            w_reqs[h].atp      = h_req_atp[h];
            w_reqs[h].prv      = h_req_prv[h];
            w_reqs[h].sum      = h_req_sum[h];
            w_reqs[h].mxr      = h_req_mxr[h];
        end
    end

    // Round-robin grant: first valid hart at or after the rr pointer, wrapping.
    always_comb begin
        w_grant   = '0;
        w_any_req = 1'b0;
        w_idx     = 0;
        for (int unsigned i = 0; i < NumHarts; i++) begin
            w_idx = (32'(r_rr) + i) % NumHarts;
            if (!w_any_req && h_req_valid[HartW'(w_idx)]) begin
                w_any_req = 1'b1;
                w_grant   = HartW'(w_idx);
            end
        end
    end

    assign w_notif_block = |h_notif_valid;
    assign m_req_valid   = ~rst_i & w_any_req & ~w_full & ~w_notif_block;
    assign w_accept      = m_req_valid & m_req_ready;
    assign w_rr_next     = HartW'((32'(w_grant) + 32'd1) % NumHarts);
    assign w_sel         = w_reqs[w_grant];

    assign m_req_address  = w_sel.address;
    assign m_req_value    = w_sel.value;
    assign m_req_op       = w_sel.op;
    assign m_req_size     = w_sel.size;
    assign m_req_size_ext = w_sel.size_ext;
    assign m_req_amo      = w_sel.amo;
    assign m_req_atp      = w_sel.atp;
    assign m_req_prv      = w_sel.prv;
    assign m_req_sum      = w_sel.sum;
    assign m_req_mxr      = w_sel.mxr;

    always_comb begin
        h_req_ready = '0;
        if (w_accept) begin
            h_req_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else if (w_accept) begin
            r_rr <= w_rr_next;
        end
    end

    dcache_harness_id_fifo #(
        .WIDTH (HartW),
        .DEPTH (QueueDepth)
    ) u_id_fifo (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_push      (w_accept),
        .i_push_data (w_grant),
        .i_pop       (w_ret_ok),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // A return is legal only with something outstanding and exactly one of resp/ex asserted.
    assign w_ret_ok  = ~rst_i & ~w_empty & (m_resp_valid ^ m_ex_valid);
    assign w_ret_err = ~rst_i & (m_resp_valid | m_ex_valid) & (w_empty | (m_resp_valid & m_ex_valid));

    always_comb begin
        h_resp_valid = '0;
        h_ex_valid   = '0;
        if (w_ret_ok) begin
            h_resp_valid[w_head] = m_resp_valid;
            h_ex_valid[w_head]   = m_ex_valid;
        end
    end

    assign h_resp_value   = {NumHarts{m_resp_value}};
    assign h_ex_exception = {NumHarts{m_ex_exception}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_ret_err) begin
            r_err <= 1'b1;
        end
    end

    // Lowest-index notification wins; it is released only once all traffic has drained.
    always_comb begin
        w_nsel   = '0;
        w_nfound = 1'b0;
        for (int unsigned i = 0; i < NumHarts; i++) begin
            if (!w_nfound && h_notif_valid[HartW'(i)]) begin
                w_nfound = 1'b1;
                w_nsel   = HartW'(i);
            end
        end
    end

    assign m_notif_valid  = ~rst_i & w_notif_block & w_empty;
    assign m_notif_reason = h_notif_reason[w_nsel];

    always_comb begin
        h_notif_ready = '0;
        h_notif_ready[w_nsel] = m_notif_valid & m_notif_ready;
    end

    assign outstanding_o = w_count;
    assign err_o         = r_err;

endmodule

// File: tb/tb_dcache_harness_arbiter.sv
// Scoreboard bench for dcache_harness_arbiter: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_dcache_harness_arbiter;
    import muntjac_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D + 1);

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [N-1:0]         h_req_valid;
    logic [N-1:0]         h_req_ready;
    logic [N-1:0][63:0]   h_req_address;
    logic [N-1:0][63:0]   h_req_value;
    mem_op_e [N-1:0]      h_req_op;
    logic [N-1:0][1:0]    h_req_size;
    size_ext_e [N-1:0]    h_req_size_ext;
    logic [N-1:0][6:0]    h_req_amo;
    logic [N-1:0][63:0]   h_req_atp;
    logic [N-1:0]         h_req_prv;
    logic [N-1:0]         h_req_sum;
    logic [N-1:0]         h_req_mxr;
    logic [N-1:0]         h_resp_valid;
    logic [N-1:0][63:0]   h_resp_value;
    logic [N-1:0]         h_ex_valid;
    exception_t [N-1:0]   h_ex_exception;
    logic [N-1:0]         h_notif_valid;
    logic [N-1:0]         h_notif_reason;
    logic [N-1:0]         h_notif_ready;
    logic                 m_req_valid;
    logic                 m_req_ready;
    logic [63:0]          m_req_address;
    logic [63:0]          m_req_value;
    mem_op_e              m_req_op;
    logic [1:0]           m_req_size;
    size_ext_e            m_req_size_ext;
    logic [6:0]           m_req_amo;
    logic [63:0]          m_req_atp;
    logic                 m_req_prv;
    logic                 m_req_sum;
    logic                 m_req_mxr;
    logic                 m_resp_valid;
    logic [63:0]          m_resp_value;
    logic                 m_ex_valid;
    exception_t           m_ex_exception;
    logic                 m_notif_valid;
    logic                 m_notif_reason;
    logic                 m_notif_ready;
    logic [CW-1:0]        outstanding_o;
    logic                 err_o;

    typedef struct {
        logic        hart;
        bit          is_ex;
        logic [63:0] value;
    } ret_t;

    localparam logic [63:0] EX_TVAL = 64'h0000_0000_DEAD_BEEF;

    logic  exp_grant_q [$];
    ret_t  exp_ret_q   [$];
    int    total = 0;
    int    bad   = 0;
    logic  mon_g;
    ret_t  mon_r;

    dcache_harness_arbiter #(.NumHarts(N), .QueueDepth(D)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .h_req_valid    (h_req_valid),
        .h_req_ready    (h_req_ready),
        .h_req_address  (h_req_address),
        .h_req_value    (h_req_value),
        .h_req_op       (h_req_op),
        .h_req_size     (h_req_size),
        .h_req_size_ext (h_req_size_ext),
        .h_req_amo      (h_req_amo),
        .h_req_atp      (h_req_atp),
        .h_req_prv      (h_req_prv),
        .h_req_sum      (h_req_sum),
        .h_req_mxr      (h_req_mxr),
        .h_resp_valid   (h_resp_valid),
        .h_resp_value   (h_resp_value),
        .h_ex_valid     (h_ex_valid),
        .h_ex_exception (h_ex_exception),
        .h_notif_valid  (h_notif_valid),
        .h_notif_reason (h_notif_reason),
        .h_notif_ready  (h_notif_ready),
        .m_req_valid    (m_req_valid),
        .m_req_ready    (m_req_ready),
        .m_req_address  (m_req_address),
        .m_req_value    (m_req_value),
        .m_req_op       (m_req_op),
        .m_req_size     (m_req_size),
        .m_req_size_ext (m_req_size_ext),
        .m_req_amo      (m_req_amo),
        .m_req_atp      (m_req_atp),
        .m_req_prv      (m_req_prv),
        .m_req_sum      (m_req_sum),
        .m_req_mxr      (m_req_mxr),
        .m_resp_valid   (m_resp_valid),
        .m_resp_value   (m_resp_value),
        .m_ex_valid     (m_ex_valid),
        .m_ex_exception (m_ex_exception),
        .m_notif_valid  (m_notif_valid),
        .m_notif_reason (m_notif_reason),
        .m_notif_ready  (m_notif_ready),
        .outstanding_o  (outstanding_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input logic h);
        exp_grant_q.push_back(h);
    endtask

    task automatic exp_ret(input logic h, input bit is_ex, input logic [63:0] v);
        ret_t r;
        r.hart  = h;
        r.is_ex = is_ex;
        r.value = v;
        exp_ret_q.push_back(r);
    endtask

    task automatic resp(input logic v, input logic [63:0] data);
        m_resp_valid = v;
        m_resp_value = data;
    endtask

    // Monitor: every accept and every routed return must match the head of its queue.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (h_req_ready != '0) begin
                if (exp_grant_q.size() == 0) begin
                    check("grant_unexpected", 64'(h_req_ready), 64'd0);
                end else begin
                    mon_g = exp_grant_q.pop_front();
                    check("grant_hart", 64'(h_req_ready), 64'(1) << mon_g);
                    check("grant_addr", m_req_address, 64'h1000 * (64'(mon_g) + 64'd1));
                    check("grant_handshake", 64'({m_req_valid, m_req_ready}), 64'd3);
                end
            end
            if (h_resp_valid != '0 || h_ex_valid != '0) begin
                if (exp_ret_q.size() == 0) begin
                    check("ret_unexpected", 64'({h_ex_valid, h_resp_valid}), 64'd0);
                end else begin
                    mon_r = exp_ret_q.pop_front();
                    if (mon_r.is_ex) begin
                        check("ex_valid", 64'(h_ex_valid), 64'(1) << mon_r.hart);
                        check("ex_resp_quiet", 64'(h_resp_valid), 64'd0);
                        check("ex_cause", 64'(h_ex_exception[mon_r.hart].cause), 64'(EXC_LOAD_ACCESS));
                        check("ex_tval", h_ex_exception[mon_r.hart].tval, mon_r.value);
                    end else begin
                        check("resp_valid", 64'(h_resp_valid), 64'(1) << mon_r.hart);
                        check("resp_ex_quiet", 64'(h_ex_valid), 64'd0);
                        check("resp_value", h_resp_value[mon_r.hart], mon_r.value);
                    end
                end
            end
        end
    end

    initial begin
        h_req_address[0] = 64'h1000;
        h_req_address[1] = 64'h2000;
        h_req_value[0]   = 64'h55;
        h_req_value[1]   = 64'h66;
        h_req_op[0]      = MEM_LOAD;
        h_req_op[1]      = MEM_STORE;
        h_req_size       = '0;
        h_req_size_ext[0] = SIZE_EXT_ZERO;
        h_req_size_ext[1] = SIZE_EXT_SIGNED;
        h_req_amo        = '0;
        h_req_atp        = '0;
        h_req_prv        = '0;
        h_req_sum        = '0;
        h_req_mxr        = '0;
        m_ex_exception   = '{cause: EXC_LOAD_ACCESS, tval: EX_TVAL};

        // Reset with every input asserted: all handshake outputs must stay low.
        rst_i          = 1'b1;
        h_req_valid    = 2'b11;
        h_notif_valid  = 2'b11;
        h_notif_reason = 2'b11;
        m_req_ready    = 1'b1;
        m_notif_ready  = 1'b1;
        m_resp_valid   = 1'b1;
        m_resp_value   = 64'h0;
        m_ex_valid     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_handshakes", 64'({h_req_ready, h_resp_valid, h_ex_valid, h_notif_ready,
                                         m_req_valid, m_notif_valid}), 64'd0);
        end
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        next();
        rst_i          = 1'b0;
        h_req_valid    = '0;
        h_notif_valid  = '0;
        h_notif_reason = '0;
        resp(1'b0, 64'h0);
        @(negedge clk);
        check("post_rst_err", 64'(err_o), 64'd0);
        check("post_rst_outstanding", 64'(outstanding_o), 64'd0);

        // Alternating grants, responses two cycles after each accept.
        next();
        exp_grant(1'b0); exp_grant(1'b1); exp_grant(1'b0);
        exp_ret(1'b0, 1'b0, 64'hA); exp_ret(1'b1, 1'b0, 64'hB); exp_ret(1'b0, 1'b0, 64'hC);
        h_req_valid = 2'b11;
        next();
        next();
        h_req_valid = 2'b01;
        resp(1'b1, 64'hA);
        next();
        h_req_valid = 2'b00;
        resp(1'b1, 64'hB);
        next();
        resp(1'b1, 64'hC);
        next();
        resp(1'b0, 64'h0);
        @(negedge clk);
        check("rr_drained", 64'(outstanding_o), 64'd0);

        // Fill to depth; a pop while full does not admit a request the same cycle.
        next();
        exp_grant(1'b1); exp_grant(1'b0); exp_grant(1'b1); exp_grant(1'b0);
        h_req_valid = 2'b11;
        for (int c = 0; c < 4; c++) next();
        @(negedge clk);
        check("full_blocks_req", 64'(m_req_valid), 64'd0);
        check("full_outstanding", 64'(outstanding_o), 64'd4);
        next();
        exp_ret(1'b1, 1'b0, 64'h30);
        resp(1'b1, 64'h30);
        @(negedge clk);
        check("full_no_bypass", 64'(m_req_valid), 64'd0);
        next();
        resp(1'b0, 64'h0);
        exp_grant(1'b1);
        h_req_valid = 2'b10;
        next();
        h_req_valid = 2'b00;
        @(negedge clk);
        check("refill_outstanding", 64'(outstanding_o), 64'd4);
        exp_ret(1'b0, 1'b0, 64'h31); exp_ret(1'b1, 1'b0, 64'h32);
        exp_ret(1'b0, 1'b0, 64'h33); exp_ret(1'b1, 1'b0, 64'h34);
        for (int c = 0; c < 4; c++) begin
            next();
            resp(1'b1, 64'h31 + 64'(c));
        end
        next();
        resp(1'b0, 64'h0);
        @(negedge clk);
        check("full_drained", 64'(outstanding_o), 64'd0);

        // Notification fences behind two outstanding requests.
        next();
        exp_grant(1'b0);
        h_req_valid = 2'b01;
        next();
        exp_grant(1'b1);
        h_req_valid = 2'b10;
        next();
        h_req_valid    = 2'b11;
        h_notif_valid  = 2'b10;
        h_notif_reason = 2'b10;
        @(negedge clk);
        check("notif_blocks_req", 64'(m_req_valid), 64'd0);
        check("notif_wait_2", 64'({m_notif_valid, h_notif_ready}), 64'd0);
        next();
        exp_ret(1'b0, 1'b0, 64'h40);
        resp(1'b1, 64'h40);
        @(negedge clk);
        check("notif_wait_1", 64'(m_notif_valid), 64'd0);
        next();
        exp_ret(1'b1, 1'b0, 64'h41);
        resp(1'b1, 64'h41);
        @(negedge clk);
        check("notif_wait_0", 64'(m_notif_valid), 64'd0);
        check("notif_req_still_blocked", 64'(m_req_valid), 64'd0);
        next();
        resp(1'b0, 64'h0);
        @(negedge clk);
        check("notif_valid", 64'(m_notif_valid), 64'd1);
        check("notif_ready", 64'(h_notif_ready), 64'd2);
        check("notif_reason", 64'(m_notif_reason), 64'd1);
        check("notif_req_blocked", 64'(m_req_valid), 64'd0);
        next();
        h_notif_valid  = 2'b00;
        h_notif_reason = 2'b00;
        exp_grant(1'b0);
        next();
        exp_grant(1'b1);
        h_req_valid = 2'b10;
        next();
        h_req_valid = 2'b00;
        exp_ret(1'b0, 1'b0, 64'h42);
        resp(1'b1, 64'h42);
        next();
        resp(1'b0, 64'h0);
        exp_ret(1'b1, 1'b1, EX_TVAL);
        m_ex_valid = 1'b1;
        next();
        m_ex_valid = 1'b0;
        @(negedge clk);
        check("ex_drained", 64'(outstanding_o), 64'd0);
        check("ex_no_err", 64'(err_o), 64'd0);

        // Protocol errors: return on empty FIFO, resp+ex together, stale return after reset.
        next();
        resp(1'b1, 64'h77);
        next();
        resp(1'b0, 64'h0);
        @(negedge clk);
        check("err_empty_return", 64'(err_o), 64'd1);
        next();
        rst_i = 1'b1;
        next();
        rst_i = 1'b0;
        @(negedge clk);
        check("err_cleared", 64'(err_o), 64'd0);
        exp_grant(1'b0);
        h_req_valid = 2'b01;
        next();
        h_req_valid = 2'b00;
        resp(1'b1, 64'h88);
        m_ex_valid = 1'b1;
        next();
        resp(1'b0, 64'h0);
        m_ex_valid = 1'b0;
        @(negedge clk);
        check("err_both_returns", 64'(err_o), 64'd1);
        check("both_returns_no_pop", 64'(outstanding_o), 64'd1);
        next();
        next();
        @(negedge clk);
        check("err_sticky", 64'(err_o), 64'd1);
        next();
        rst_i = 1'b1;
        next();
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_clears_fifo", 64'(outstanding_o), 64'd0);
        check("rst_clears_err", 64'(err_o), 64'd0);
        next();
        resp(1'b1, 64'h99);
        next();
        resp(1'b0, 64'h0);
        @(negedge clk);
        check("err_stale_return", 64'(err_o), 64'd1);

        next();
        next();
        check("grant_q_drained", 64'(exp_grant_q.size()), 64'd0);
        check("ret_q_drained", 64'(exp_ret_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
